// File: rtl/bus_memory_responder.sv
// Memory-side responder for the top8227 CPU bus: decodes each cycle,
// serves reads with programmable wait states, performs writes, holds the
// six-byte vector bank, accepts host preloads and counts opcode fetches.
// All state advances on the falling edge of clk.
module bus_memory_responder #(
  parameter logic [15:0] RAM_BASE     = 16'h0000,
  parameter int          RAM_DEPTH    = 2048,
  parameter int          WAIT_STATES  = 0,
  parameter logic [15:0] NMI_VECTOR   = 16'h0000,
  parameter logic [15:0] RESET_VECTOR = 16'hCCDD,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  AddressBusHigh,
  input  logic [7:0]  AddressBusLow,
  input  logic        readNotWrite,
  input  logic [7:0]  dataBusOutput,
  input  logic        dataBusEnable,
  input  logic        sync,
  output logic [7:0]  dataBusInput,
  output logic        ready,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  output logic [15:0] fetch_count,
  output logic        bus_error
);

  localparam int          RAM_AW   = $clog2(RAM_DEPTH);
  localparam logic [2:0]  WAIT_MAX = 3'(WAIT_STATES);
  // Vector bank bytes in address order FFFA..FFFF.
  localparam logic [47:0] VEC_INIT = {IRQ_VECTOR, RESET_VECTOR, NMI_VECTOR};

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_SERVE} state_t;
  localparam state_t RESET_STATE = (WAIT_STATES == 0) ? ST_SERVE : ST_WAIT;

  // Address decode helpers; the vector bank takes priority over RAM.
  function automatic logic inVec(input logic [15:0] a);
    return a >= 16'hFFFA;
  endfunction

  function automatic logic inRam(input logic [15:0] a);
    logic [16:0] off;
    // A borrow (a below the base) makes off huge, so one compare covers both ends.
    off = {1'b0, a} - {1'b0, RAM_BASE};
    return off < 17'(RAM_DEPTH);
  endfunction

  function automatic logic [RAM_AW-1:0] ramIndex(input logic [15:0] a);
    return RAM_AW'(a - RAM_BASE);
  endfunction

  function automatic logic [2:0] vecIndex(input logic [15:0] a);
    return 3'(a - 16'hFFFA);
  endfunction

  logic [7:0]  ram [0:RAM_DEPTH-1];
  logic [7:0]  vecReg [0:5];

  logic [15:0] cpuAddr;
  logic        cpuMapped;
  logic [7:0]  readByte;

  state_t      stateReg, stateNext;
  logic [2:0]  waitCountReg, waitCountNext;
  logic [15:0] pendAddrReg, pendAddrNext;
  logic [7:0]  dataReg, dataNext;
  logic        readyReg, readyNext;
  logic [15:0] fetchReg, fetchNext;
  logic        errorReg, errorNext;

  logic        newAccess;
  logic [2:0]  countNow;
  logic        wrEn;
  logic [15:0] wrAddr;
  logic [7:0]  wrData;

  assign cpuAddr      = {AddressBusHigh, AddressBusLow};
  assign cpuMapped    = inVec(cpuAddr) || inRam(cpuAddr);
  assign dataBusInput = dataReg;
  assign ready        = readyReg;
  assign fetch_count  = fetchReg;
  assign bus_error    = errorReg;

  // Byte visible at the CPU address; unmapped space reads as FF.
  always_comb begin
    readByte = 8'hFF;
    if (inVec(cpuAddr)) begin
      case (vecIndex(cpuAddr))
        3'd0:    readByte = vecReg[0];
        3'd1:    readByte = vecReg[1];
        3'd2:    readByte = vecReg[2];
        3'd3:    readByte = vecReg[3];
        3'd4:    readByte = vecReg[4];
        default: readByte = vecReg[5];
      endcase
    end else if (inRam(cpuAddr)) begin
      readByte = ram[ramIndex(cpuAddr)];
    end
  end

  // Next-state and output decision: preload beats CPU, reads count wait
  // states, writes always complete on the first edge.
  always_comb begin
    stateNext     = stateReg;
    waitCountNext = waitCountReg;
    pendAddrNext  = pendAddrReg;
    dataNext      = dataReg;
    readyNext     = readyReg;
    fetchNext     = fetchReg;
    errorNext     = errorReg;
    newAccess     = 1'b0;
    countNow      = 3'd0;
    wrEn          = 1'b0;
    wrAddr        = cpuAddr;
    wrData        = dataBusOutput;
    if (load_en) begin
      stateNext     = ST_LOAD;
      waitCountNext = 3'd0;
      readyNext     = 1'b0;
      wrAddr        = load_addr;
      wrData        = load_data;
      if (inVec(load_addr) || inRam(load_addr)) wrEn = 1'b1;
      else                                       errorNext = 1'b1;
    end else if (readNotWrite) begin
      // A read coming from another state or to a different address starts over.
      newAccess = (stateReg != ST_WAIT) || (cpuAddr != pendAddrReg);
      countNow  = newAccess ? 3'd0 : waitCountReg;
      if (countNow == WAIT_MAX) begin
        stateNext     = ST_SERVE;
        waitCountNext = 3'd0;
        readyNext     = 1'b1;
        dataNext      = readByte;
        if (!cpuMapped) errorNext = 1'b1;
        if (sync && (fetchReg != 16'hFFFF)) fetchNext = fetchReg + 16'd1;
      end else begin
        stateNext     = ST_WAIT;
        waitCountNext = countNow + 3'd1;
        readyNext     = 1'b0;
        pendAddrNext  = cpuAddr;
      end
    end else begin
      stateNext     = ST_SERVE;
      waitCountNext = 3'd0;
      readyNext     = 1'b1;
      if (dataBusEnable && cpuMapped) wrEn = 1'b1;
      else                            errorNext = 1'b1;
    end
  end

  // Control and output registers.
  always_ff @(negedge clk or negedge nrst) begin
    if (!nrst) begin
      stateReg     <= RESET_STATE;
      waitCountReg <= 3'd0;
      pendAddrReg  <= 16'h0000;
      dataReg      <= 8'h00;
      readyReg     <= 1'b0;
      fetchReg     <= 16'h0000;
      errorReg     <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      waitCountReg <= waitCountNext;
      pendAddrReg  <= pendAddrNext;
      dataReg      <= dataNext;
      readyReg     <= readyNext;
      fetchReg     <= fetchNext;
      errorReg     <= errorNext;
    end
  end

  // RAM write port; contents are not reset, and writes are blocked while in reset.
  always_ff @(negedge clk) begin
    if (nrst && wrEn && !inVec(wrAddr) && inRam(wrAddr)) ram[ramIndex(wrAddr)] <= wrData;
  end

  // Vector bank: one register per byte, reloaded with the parameter vectors on reset.
  for (genvar gi = 0; gi < 6; gi++) begin : gVec
    always_ff @(negedge clk or negedge nrst) begin
      if (!nrst)                                                       vecReg[gi] <= VEC_INIT[gi*8 +: 8];
      else if (wrEn && inVec(wrAddr) && (vecIndex(wrAddr) == 3'(gi))) vecReg[gi] <= wrData;
    end
  end

endmodule
